window_sum_ctrl: RTL and testbench
==================================

Name: window_sum_ctrl

Overview:
- Sequencing controller for a sliding-window ("past sequence") adder.
- Accepts a stream of samples over a valid/ready handshake and keeps a 2^N-deep history buffer.
- Maintains a running sum of the last 2^N accepted samples: add the newest, subtract the evicted one.
- Handles the clear/fill/run phases and asserts a sum-valid only once the window is full.

Parameters:
- data_width, 4: sample width and (default build) sum width.
- N, 3: log2 of the window depth; the window holds W = 2^N samples.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  request to clear history and sum.
- in_valid  in  1  sample present.
- in_data  in  data_width  sample value, unsigned.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  one-cycle pulse: out_sum is a full-window sum.
- out_sum  out  SW  running sum. SW = data_width by default; see Optional Feature.
- busy  out  1  high while clearing (FLUSH state).

Behaviour:
- States are FLUSH, FILL and RUN.
- Reset, sampled high at an edge:
  - state <= FLUSH, clear pointer <= 0, write pointer <= 0, fill count <= 0.
  - out_sum <= 0, out_valid <= 0.
  - After the edge: busy=1, in_ready=0.
- FLUSH:
  - Lasts exactly W cycles; each cycle writes 0 to history[clear pointer] and increments the pointer.
  - On the cycle the last entry is written, next state is FILL.
  - in_ready=0, out_valid=0, out_sum held at 0.
- Handshake:
  - in_ready = (state != FLUSH) && !flush && !rst. It is combinational.
  - A sample is accepted when in_valid && in_ready at a rising edge.
  - in_data must be held stable while in_valid=1 and in_ready=0.
- Accept, in FILL or RUN:
  - history[wp] <= in_data; wp <= wp+1, wrapping mod W.
  - out_sum <= out_sum + in_data - history[wp]. The evicted entry is 0 during FILL.
  - Arithmetic is mod 2^SW.
  - Latency is one edge: the new sum is visible right after the accepting edge.
- FILL:
  - The fill count increments on each accept.
  - The accept that brings the count to W moves to RUN and sets out_valid=1 in the same update. That is the W-th sample.
- RUN:
  - Every accept sets out_valid=1 for one cycle.
  - Cycles without an accept set out_valid=0 and hold out_sum.
- Flush:
  - flush sampled high in FILL or RUN: state <= FLUSH, pointers and fill count <= 0, out_sum <= 0, out_valid <= 0.
  - in_ready is 0 in that cycle, so no sample is accepted or lost silently.
  - flush high during FLUSH is ignored; the sequence does not restart.
- Priority: rst > flush > accept.
- Reset mid-operation is identical to the reset above and restarts the full W-cycle clear.

Optional Feature:
- Macro: WINDOW_SUM_FULL_WIDTH_EN.
- Defined:
  - SW = data_width + N.
  - out_sum is the exact sum of the window with no wrap.
  - The internal accumulator and subtract use SW bits.
- Undefined (default):
  - SW = data_width, and the sum wraps mod 2^data_width.
  - This matches the existing past-sequence adder output width.

Test Plan (data_width=4, N=3, W=8):
1. Reset, then idle. rst high for 2 cycles, then low:
   - busy=1 and in_ready=0 for exactly 8 cycles after release.
   - Then busy=0, in_ready=1, out_sum=0, out_valid=0.
2. Fill and slide. Feed 1..8 back-to-back:
   - out_valid=0 for the first 7 samples.
   - On the 8th: out_valid=1, out_sum=36 mod 16=4.
   - Feed 9: out_valid=1, out_sum=44 mod 16=12.
3. Stalls:
   - In RUN, drop in_valid for 3 cycles: out_valid=0 and out_sum unchanged.
   - Resume with 0: out_sum decreases by the evicted value.
4. Flush mid-RUN with in_valid=1:
   - in_ready=0 in that cycle and the sample is not taken.
   - busy=1 for 8 cycles, out_sum=0.
   - Then feed 3 eight times: out_valid=1 only on the 8th, out_sum=24 mod 16=8.
5. Reset during FILL, after 4 samples:
   - Full 8-cycle clear, fill count restarts.
   - out_valid first pulses after 8 new accepts.
6. With WINDOW_SUM_FULL_WIDTH_EN defined:
   - Scenario 2 gives out_sum=36, then 44 (7-bit output).
   - Feeding 15 eight times gives 120.

Source files
------------

// File: rtl/window_sum_if.sv
// Sample-stream and status bundle for window_sum_ctrl.
// Width selection follows the WINDOW_SUM_FULL_WIDTH_EN build macro, so the
// sum is the same width here as in the controller.
//
// Handshake: a sample moves on a rising clk edge where in_valid && in_ready.
// in_ready never depends on in_valid. While in_valid=1 and in_ready=0 the
// producer holds in_data stable. out_valid is a one-cycle pulse qualifying
// out_sum; there is no backpressure on the output side.
interface window_sum_if #(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 3
);
`ifdef WINDOW_SUM_FULL_WIDTH_EN
  localparam int SW = DATA_WIDTH + N;
`else
  localparam int SW = DATA_WIDTH;
`endif

  logic                  flush;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [SW-1:0]         out_sum;
  logic                  busy;

  modport master (
    output flush, in_valid, in_data,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  flush, in_valid, in_data,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/window_sum_ctrl.sv
// Sliding-window sum controller: keeps a 2^N-deep sample history and a
// running sum of the last 2^N accepted samples (add newest, subtract evicted).
// Phases: FLUSH clears the history one entry per cycle, FILL loads the first
// window, RUN emits a full-window sum on every accept.
// Build macro WINDOW_SUM_FULL_WIDTH_EN widens the sum to data_width+N bits so
// it never wraps; by default the sum is data_width bits and wraps.
module window_sum_ctrl #(
  parameter int data_width = 4,
  parameter int N          = 3
) (
  input  logic         clk,
  input  logic         rst,
  window_sum_if.slave  bus,
  output logic [1:0]   dbg_state_o
);

`ifdef WINDOW_SUM_FULL_WIDTH_EN
  localparam int SW = data_width + N;
`else
  localparam int SW = data_width;
`endif
  localparam int W = 1 << N;
  localparam logic [N-1:0] LAST = N'(W - 1);

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [N-1:0]          clr_ptr_q, clr_ptr_d;
  logic [N-1:0]          wp_q, wp_d;
  logic [N-1:0]          fill_cnt_q, fill_cnt_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] hist_q [W];
  logic [data_width-1:0] evict;
  logic                  in_ready;
  logic                  accept;

  // Ready is purely a function of phase, flush and reset, never of in_valid.
  assign in_ready = (state_q != ST_FLUSH) && !bus.flush && !rst;
  assign accept   = bus.in_valid && in_ready;

  // History is all zeros during FILL, but force it so the sum cannot pick up stale data.
  assign evict = (state_q == ST_FILL) ? '0 : hist_q[wp_q];

  // Next-state and datapath update for phases, pointers, fill count and sum.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wp_d        = wp_q;
    fill_cnt_d  = fill_cnt_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        clr_ptr_d = clr_ptr_q + N'(1);
        sum_d     = '0;
        if (clr_ptr_q == LAST) state_d = ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        if (bus.flush) begin
          state_d    = ST_FLUSH;
          clr_ptr_d  = '0;
          wp_d       = '0;
          fill_cnt_d = '0;
          sum_d      = '0;
        end else if (accept) begin
          wp_d  = wp_q + N'(1);
          sum_d = sum_q + SW'(bus.in_data) - SW'(evict);
          if (state_q == ST_FILL) begin
            fill_cnt_d = fill_cnt_q + N'(1);
            if (fill_cnt_q == LAST) begin
              state_d     = ST_RUN;
              out_valid_d = 1'b1;
            end
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_FLUSH;
        clr_ptr_d = '0;
        sum_d     = '0;
      end
    endcase
  end

  // Control and sum registers; reset restarts the full clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      clr_ptr_q   <= '0;
      wp_q        <= '0;
      fill_cnt_q  <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wp_q        <= wp_d;
      fill_cnt_q  <= fill_cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  // History storage: zeroed entry by entry in FLUSH, overwritten on accept.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_FLUSH) begin
      hist_q[clr_ptr_q] <= '0;
    end else if (accept) begin
      hist_q[wp_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.busy      = (state_q == ST_FLUSH);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_window_sum_ctrl.sv
// Bench for window_sum_ctrl: directed scenarios with literal sums plus a long
// randomized run, all checked every cycle against a queue-based window model.
module tb_window_sum_ctrl;
  localparam int DW = 4;
  localparam int NN = 3;
  localparam int W  = 8;
`ifdef WINDOW_SUM_FULL_WIDTH_EN
  localparam int SW = DW + NN;
`else
  localparam int SW = DW;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;

  window_sum_if #(.DATA_WIDTH(DW), .N(NN)) bus ();

  window_sum_ctrl #(.data_width(DW), .N(NN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint lit(input int v);
    return longint'(v % (1 << SW));
  endfunction

  // Reference model: the window is simply the last W accepted samples since
  // the most recent clear; the clear phase is a countdown of W cycles.
  int              clear_left = 0;
  bit              started    = 1'b0;
  bit              m_valid    = 1'b0;
  logic [SW-1:0]   m_sum      = '0;
  logic [DW-1:0]   win[$];
  logic [SW-1:0]   exp_q[$];

  always @(posedge clk) begin
    int tot;
    m_valid = 1'b0;
    if (rst) begin
      started    = 1'b1;
      clear_left = W;
      win.delete();
    end else if (!started) begin
      clear_left = 0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (bus.flush) begin
      clear_left = W;
      win.delete();
    end else if (bus.in_valid) begin
      win.push_back(bus.in_data);
      if (win.size() > W) void'(win.pop_front());
      if (win.size() == W) m_valid = 1'b1;
    end
    tot = 0;
    foreach (win[i]) tot += int'(win[i]);
    m_sum = tot[SW-1:0];
    if (m_valid) exp_q.push_back(m_sum);
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("busy", longint'(bus.busy), longint'(clear_left > 0));
      chk("in_ready", longint'(bus.in_ready),
          longint'(clear_left == 0 && !bus.flush && !rst));
      chk("out_valid", longint'(bus.out_valid), longint'(m_valid));
      chk("out_sum", longint'(bus.out_sum), longint'(m_sum));
      chk("legal_state", longint'(dbg_state == 2'd3), 0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
        else chk("sb_sum", longint'(bus.out_sum), longint'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    int n = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    tick();
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else break;
    end
  endtask

  initial begin
    int cnt;
    int s;
    bit hold;
    logic [DW-1:0] v;

    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset then idle.
    tick(); tick();
    rst = 1'b0;
    count_busy(cnt);
    chk("reset_busy_cycles", cnt, 8);
    tick();
    chk("idle_ready", longint'(bus.in_ready), 1);
    chk("idle_sum", longint'(bus.out_sum), 0);
    chk("idle_valid", longint'(bus.out_valid), 0);

    // Fill and slide with 1..9.
    for (int k = 1; k <= 8; k++) begin
      send(DW'(k));
      if (k < 8) chk("fill_no_valid", longint'(bus.out_valid), 0);
    end
    chk("fill8_valid", longint'(bus.out_valid), 1);
    chk("fill8_sum", longint'(bus.out_sum), lit(36));
    send(DW'(9));
    chk("slide9_valid", longint'(bus.out_valid), 1);
    chk("slide9_sum", longint'(bus.out_sum), lit(44));

    // Stalls hold the sum; resuming with 0 subtracts the evicted 2.
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", longint'(bus.out_valid), 0);
      chk("stall_sum", longint'(bus.out_sum), lit(44));
    end
    send('0);
    chk("resume_valid", longint'(bus.out_valid), 1);
    chk("resume_sum", longint'(bus.out_sum), lit(42));

    // Flush mid-RUN with a sample offered.
    bus.in_data  = 4'd5;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("flush_ready_low", longint'(bus.in_ready), 0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_sum_zero", longint'(bus.out_sum), 0);
    count_busy(cnt);
    chk("flush_busy_cycles", cnt, 8);
    tick();
    for (int k = 1; k <= 8; k++) begin
      send(4'd3);
      if (k < 8) chk("refill_no_valid", longint'(bus.out_valid), 0);
    end
    chk("refill_valid", longint'(bus.out_valid), 1);
    chk("refill_sum", longint'(bus.out_sum), lit(24));

    // Reset during FILL after 4 samples.
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    count_busy(cnt);
    tick();
    for (int k = 0; k < 4; k++) send(DW'($urandom_range(0, 15)));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(cnt);
    chk("midfill_reset_busy", cnt, 8);
    tick();
    s = 0;
    for (int k = 1; k <= 8; k++) begin
      v = DW'($urandom_range(0, 15));
      s += int'(v);
      send(v);
      if (k < 8) chk("post_reset_no_valid", longint'(bus.out_valid), 0);
    end
    chk("post_reset_valid", longint'(bus.out_valid), 1);
    chk("post_reset_sum", longint'(bus.out_sum), lit(s));

    // Maximum samples: exact 120 in full width, wrapped otherwise.
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    count_busy(cnt);
    tick();
    for (int k = 0; k < 8; k++) send(4'd15);
    chk("max_sum", longint'(bus.out_sum), lit(120));

    // Randomized traffic with occasional flush and reset.
    hold = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = DW'($urandom_range(0, 15));
      end
      bus.flush = ($urandom_range(0, 60) == 0);
      rst       = ($urandom_range(0, 250) == 0);
      #1;
      hold = bus.in_valid && !bus.in_ready;
      tick();
    end
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick(); tick();

    chk("sb_queue_empty", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
